// File: rtl/div_seq_32.sv
// Sequential 32-bit restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_SIGNED_EN to enable signed ops; otherwise op[0] is ignored and all ops are unsigned.
module div_seq_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        valid,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [31:0] acc;       // partial remainder
    logic [31:0] quo;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [31:0] dvsr;
    logic [4:0]  cnt;
    logic        is_rem;

    logic [31:0] dend_mag;
    logic [31:0] dvsr_mag;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {acc, quo[31]};
    // acc < dvsr keeps the difference within 33-bit signed range, so bit 32 is the borrow
    assign diff    = shifted - {1'b0, dvsr};

`ifdef DIV_SIGNED_EN
    logic is_signed;
    logic neg_q;
    logic neg_r;

    assign is_signed = ~op[0];
    assign dend_mag  = (is_signed && dividend[31]) ? -dividend : dividend;
    assign dvsr_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;
    assign q_fix     = neg_q ? -quo : quo;
    assign r_fix     = neg_r ? -acc : acc;

    // Divide-by-zero keeps the all-ones quotient regardless of the dividend sign
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start && (state == IDLE || state == DONE)) begin
            neg_q <= is_signed && (dividend[31] ^ divisor[31]) && (divisor != 32'd0);
            neg_r <= is_signed && dividend[31];
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign dend_mag   = dividend;
    assign dvsr_mag   = divisor;
    assign q_fix      = quo;
    assign r_fix      = acc;
`endif

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            result <= 32'd0;
            cnt    <= 5'd0;
            acc    <= 32'd0;
            quo    <= 32'd0;
            dvsr   <= 32'd0;
            is_rem <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        acc    <= 32'd0;
                        quo    <= dend_mag;
                        dvsr   <= dvsr_mag;
                        is_rem <= op[1];
                        cnt    <= 5'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (diff[32]) begin
                        acc <= shifted[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end else begin
                        acc <= diff[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    result <= is_rem ? r_fix : q_fix;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_32.sv
// Self-checking bench for div_seq_32: directed corner cases plus random ops against an arithmetic model.
module tb_div_seq_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    div_seq_32 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .valid    (valid),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain division semantics, with the divide-by-zero rule layered on top
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic   uns;
`ifdef DIV_SIGNED_EN
        uns = o[0];
`else
        uns = 1'b1;
`endif
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (uns) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    // Present a start; returns #1 after the accepting edge with operand inputs scrambled
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait for valid with a bounded budget; leaves us #1 into the valid cycle
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_latency"}, lat, 33);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b);
        wait_result(tag, ref_div(o, a, b));
        @(posedge clk); #1;
        check({tag, "_valid_pulse"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] a, b;
        int          nv;
        int          lat;

        rst = 1'b1; start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_result", result, 32'd0);

        // First start is accepted on the very first edge with rst low
        rst = 1'b0;
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        check("divu_100_7_const", result, 32'h0000_000E);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        check("remu_100_7_const", result, 32'h0000_0002);

        run_op("divu_5_0", 2'b01, 32'd5, 32'd0);
        check("divu_5_0_const", result, 32'hFFFF_FFFF);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0);
        check("remu_5_0_const", result, 32'h0000_0005);
        run_op("div_m5_0", 2'b00, 32'hFFFF_FFFB, 32'd0);
        check("div_m5_0_const", result, 32'hFFFF_FFFF);
        run_op("rem_m5_0", 2'b10, 32'hFFFF_FFFB, 32'd0);
        check("rem_m5_0_const", result, 32'hFFFF_FFFB);

`ifdef DIV_SIGNED_EN
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2_const", result, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        check("rem_m7_2_const", result, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", result, 32'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem_ovf_const", result, 32'h0000_0000);
`endif

        // Back-to-back: start during the DONE cycle is accepted while valid still pulses
        issue(2'b01, 32'd1000, 32'd33);
        wait_result("b2b_first", ref_div(2'b01, 32'd1000, 32'd33));
        issue(2'b10, 32'hFFFF_FF00, 32'd7);
        check("b2b_valid_drop", {31'd0, valid}, 32'd0);
        wait_result("b2b_second", ref_div(2'b10, 32'hFFFF_FF00, 32'd7));
        @(posedge clk); #1;

        // A start pulse while busy must not disturb the in-flight op
        issue(2'b01, 32'd123456, 32'd789);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b11; dividend = 32'd50; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0; lat = 0;
        for (int i = 6; i <= 45; i++) begin
            @(posedge clk); #1;
            if (valid) begin
                nv++;
                if (lat == 0) begin
                    lat = i;
                    check("ignore_result", result, ref_div(2'b01, 32'd123456, 32'd789));
                end
            end
        end
        check("ignore_latency", lat, 33);
        check("ignore_valid_count", nv, 1);

        // Reset mid-CALC aborts with no valid pulse
        issue(2'b01, 32'hDEAD_BEEF, 32'd17);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_result", result, 32'd0);
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        run_op("divu_9_3", 2'b01, 32'd9, 32'd3);
        check("divu_9_3_const", result, 32'h0000_0003);

        // Random ops with a bias toward boundary operands
        for (int t = 0; t < 60; t++) begin
            o = 2'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'd1;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(2, 100));
                4: b = a;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d_op%0d", t, o), o, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq_32.md
DIV_SEQ_32 -- requirements
Module: div_seq_32

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
REQ-002 start  in  1  request; sampled only when busy=0.
REQ-003 op  in  2  operation select:
- op[1]=1: remainder, op[1]=0: quotient.
- op[0]=1: unsigned, op[0]=0: signed.
- Encoding matches funct3[1:0]: DIV=00, DIVU=01, REM=10, REMU=11.
REQ-004 dividend  in  32  numerator; captured on accepted start.
REQ-005 divisor  in  32  denominator; captured on accepted start.
REQ-006 busy  out  1  high from the edge after an accepted start until the edge on which valid rises.
REQ-007 valid  out  1  single-cycle completion pulse.
REQ-008 result  out  32  quotient or remainder; held from valid until the next accepted start or reset.

Function
REQ-009 States SHALL be IDLE, CALC, FIX and DONE:
- IDLE/DONE + start -> CALC.
- CALC -> FIX after 32 iterations.
- FIX -> DONE.
- DONE -> IDLE when start=0.
REQ-010 On an accepted start the block SHALL latch op and operands, and form 32-bit magnitudes of both operands when signed.
REQ-011 Each CALC cycle SHALL perform one restoring step:
- Shift the remainder left, bringing in the next dividend MSB.
- Do a 33-bit trial subtract of the divisor magnitude.
- If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
REQ-012 A 5-bit counter SHALL count iterations 0..31; CALC SHALL exit when the count is 31.
REQ-013 FIX SHALL apply signs and register the result:
- Quotient is negated when the operand signs differ.
- Remainder takes the sign of the dividend.
- Unsigned ops are not sign-corrected.
REQ-014 Latency: start sampled at edge N -> valid=1 and the new result visible during the cycle after edge N+33; valid=0 after edge N+34.
REQ-015 Divisor=0 SHALL yield a quotient of 0xFFFFFFFF and a remainder equal to the dividend, for both signed and unsigned ops, with the same latency.
REQ-016 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield a quotient of 0x80000000 and a remainder of 0x00000000.
REQ-017 start asserted while busy=1 SHALL be ignored, leaving the in-flight operation unaffected.
REQ-018 start asserted in the DONE cycle SHALL be accepted; valid still pulses for that cycle.
REQ-019 Operand inputs SHALL be don't-care except on the accepted-start edge.

Reset
REQ-020 rst=1 at any edge SHALL force: state IDLE, busy=0, valid=0, result=0x00000000, counter=0.
REQ-021 Reset SHALL take priority over start.
REQ-022 Reset mid-operation SHALL abort the operation with no valid pulse.
REQ-023 The first start is accepted on the first edge with rst=0.

Configuration
REQ-024 Macro DIV_SIGNED_EN controls signed support:
- Defined: signed ops follow REQ-010, REQ-013 and REQ-016.
- Undefined: op[0] is ignored and all ops are treated as unsigned; magnitude and sign-fix logic is omitted; latency is unchanged.

Verification
REQ-025 DIVU 100/7 -> result 0x0000000E; REMU 100/7 -> 0x00000002; valid exactly 33 edges after start.
REQ-026 DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF (with DIV_SIGNED_EN).
REQ-027 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005; DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB.
REQ-028 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
REQ-029 Second start pulsed at cycle 5 of a busy operation -> ignored; first result is correct; exactly one valid pulse.
REQ-030 rst at cycle 10 of CALC -> busy=0, result=0, no valid pulse; a following start of DIVU 9/3 -> 0x00000003.
